// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory stage: store/load size codes and FSM states.
package dmem_pkg;

  // Store size codes; 2'd3 is illegal
  localparam logic [1:0] SZ_W = 2'd0;
  localparam logic [1:0] SZ_B = 2'd1;
  localparam logic [1:0] SZ_H = 2'd2;

  // Load size codes; 3'd5..3'd7 are illegal
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_BU = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_H  = 3'd4;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store lane mask and replicated data, load shift/width,
// and the misalignment flag for whichever strobe is active.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  ssize,
  input  logic [2:0]  lsize,
  input  logic [1:0]  boff,
  input  logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [4:0]  rshift,
  output logic [31:0] rmask,
  output logic        misalign
);

  logic st_bad;
  logic ld_bad;

  // Store side: lane mask, data replication, store alignment
  always_comb begin
    wmask     = 4'b0000;
    wdata_rep = wdata;
    st_bad    = 1'b0;
    case (ssize)
      SZ_W: begin
        wmask  = 4'b1111;
        st_bad = (boff != 2'b00);
      end
      SZ_B: begin
        wmask     = 4'b0001 << boff;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        wmask     = 4'b0011 << {boff[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        st_bad    = boff[0];
      end
      default: st_bad = 1'b1;
    endcase
  end

  // Load side: shift to bit 0 and width mask; sign extension is the core's job
  always_comb begin
    rshift = 5'd0;
    rmask  = 32'h0000_0000;
    ld_bad = 1'b0;
    case (lsize)
      LD_W: begin
        rmask  = 32'hFFFF_FFFF;
        ld_bad = (boff != 2'b00);
      end
      LD_BU, LD_B: begin
        rshift = {boff, 3'b000};
        rmask  = 32'h0000_00FF;
      end
      LD_HU, LD_H: begin
        rshift = {boff[1], 4'b0000};
        rmask  = 32'h0000_FFFF;
        ld_bad = boff[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Only the size code of an active strobe can fault the access
  assign misalign = (wr & st_bad) | (rd & ld_bad);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: owns the data RAM, zero-fills it after reset, serves
// lane-aligned loads combinationally and masked stores on the clock edge,
// and records the first faulting access.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W = 11,
  parameter logic [31:0] BASE   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        r,
  input  logic        w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  ssize,
  input  logic [2:0]  lsize,
  input  logic        clr_err,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] cnt;

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic              run;
  logic              fault;
  logic              wr_en;
  logic              rd_en;

  logic [3:0]        wmask;
  logic [31:0]       wdata_rep;
  logic [4:0]        rshift;
  logic [31:0]       rmask;
  logic              misalign;

  // BASE is word aligned, so off[1:0] doubles as the byte offset
  assign off = addr - BASE;
  assign idx = off[ADDR_W+1:2];
  assign oor = |off[31:ADDR_W+2];

  dmem_lane u_lane (
    .rd        (r),
    .wr        (w),
    .ssize     (ssize),
    .lsize     (lsize),
    .boff      (off[1:0]),
    .wdata     (wdata),
    .wmask     (wmask),
    .wdata_rep (wdata_rep),
    .rshift    (rshift),
    .rmask     (rmask),
    .misalign  (misalign)
  );

  assign run   = (state == ST_RUN);
  assign fault = run & cs & (r | w) & (misalign | oor);
  assign wr_en = run & cs & w & ~misalign & ~oor;
  assign rd_en = run & cs & r & ~misalign & ~oor;

  // Read path sees pre-edge RAM, so a same-cycle store shows up next cycle
  assign rdata = rd_en ? ((mem[idx] >> rshift) & rmask) : 32'h0000_0000;

  // Fill sequencer: one word per cycle, ready on the edge entering RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == ST_INIT) begin
      if (cnt == '1) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sticky error; a fault beats clr_err and then takes the new address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      err_addr <= 32'h0000_0000;
    end else if (fault) begin
      err <= 1'b1;
      if (!err || clr_err) err_addr <= addr;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

  // RAM write port: zero-fill during INIT, byte-masked stores in RUN
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= 32'h0000_0000;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: word-level reference model checked every cycle, plus
// directed accesses with literal expected values.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, r, w, clr_err;
  logic [31:0] addr, wdata;
  logic [1:0]  ssize;
  logic [2:0]  lsize;
  logic [31:0] rdata, err_addr;
  logic        ready, err;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.ADDR_W(11), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .cs(cs), .r(r), .w(w), .addr(addr), .wdata(wdata),
    .ssize(ssize), .lsize(lsize), .clr_err(clr_err), .rdata(rdata),
    .ready(ready), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_fill;
  logic        m_ready, m_err;
  logic [31:0] m_eaddr;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

  function automatic int m_word();
    logic [31:0] o;
    o = addr - BASE;
    return int'(o / 4) % DEPTH;
  endfunction

  function automatic logic m_fault();
    logic [31:0] o;
    logic oor, ld_ok, st_ok;
    o   = addr - BASE;
    oor = (o >= DEPTH * 4);
    case (lsize)
      3'd0:       ld_ok = (addr % 4 == 0);
      3'd1, 3'd3: ld_ok = 1'b1;
      3'd2, 3'd4: ld_ok = (addr % 2 == 0);
      default:    ld_ok = 1'b0;
    endcase
    case (ssize)
      2'd0:    st_ok = (addr % 4 == 0);
      2'd1:    st_ok = 1'b1;
      2'd2:    st_ok = (addr % 2 == 0);
      default: st_ok = 1'b0;
    endcase
    return cs && (r || w) && (oor || (r && !ld_ok) || (w && !st_ok));
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] wd;
    int b;
    if (!m_ready || !cs || !r || m_fault()) return 32'h0;
    wd = m_mem[m_word()];
    b  = int'(addr % 4);
    case (lsize)
      3'd1, 3'd3: return (wd / (32'h1 << (8 * b))) % 32'h100;
      3'd2, 3'd4: return (wd / (32'h1 << (8 * b))) % 32'h10000;
      default:    return wd;
    endcase
  endfunction

  // Advance the model by the upcoming rising edge (inputs are stable here)
  task automatic m_step();
    int b;
    if (!m_ready) begin
      m_mem[m_fill] = 32'h0;
      m_fill++;
      if (m_fill == DEPTH) m_ready = 1'b1;
    end else if (m_fault()) begin
      if (!m_err || clr_err) m_eaddr = addr;
      m_err = 1'b1;
    end else begin
      if (clr_err) m_err = 1'b0;
      if (cs && w) begin
        b = int'(addr % 4);
        case (ssize)
          2'd0: m_mem[m_word()] = wdata;
          2'd1: m_mem[m_word()][8*b +: 8] = wdata[7:0];
          2'd2: m_mem[m_word()][8*b +: 16] = wdata[15:0];
          default: ;
        endcase
      end
    end
  endtask

  // Compare process: every falling edge, then step the model
  always @(negedge clk) begin
    if (!rst) begin
      m_fill = 0; m_ready = 1'b0; m_err = 1'b0; m_eaddr = 32'h0;
    end
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("err_addr", err_addr, m_eaddr);
    chk("rdata", rdata, m_rdata());
    if (rst) m_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic acc(input logic c, input logic rr, input logic ww, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] ss, input logic [2:0] ls,
                     input logic cl);
    @(posedge clk); #1;
    cs = c; r = rr; w = ww; addr = a; wdata = d; ssize = ss; lsize = ls; clr_err = cl;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 1'b0, BASE, 32'h0, SZ_B, LD_BU, 1'b0);
  endtask

  // Count rising edges after release until ready, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0; cs = 1'b0; r = 1'b0; w = 1'b0; clr_err = 1'b0;
    addr = BASE; wdata = 32'h0; ssize = SZ_B; lsize = LD_BU;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; cs = 1'b1; w = 1'b1; wdata = 32'hFFFF_FFFF; ssize = SZ_W;
    wait_ready(n);
    chk("fill_cycles", n, 32'd2048);
    cs = 1'b1; r = 1'b1; w = 1'b0; lsize = LD_W; ssize = SZ_B;
    @(negedge clk);
    chk("lit_fill_rd0", rdata, 32'h0);
    chk("lit_fill_err", {31'b0, err}, 32'h0);

    acc(1, 0, 1, BASE + 8,  32'h1122_3344, SZ_W, LD_BU, 0);
    acc(1, 0, 1, BASE + 9,  32'h0000_00AA, SZ_B, LD_BU, 0);
    acc(1, 0, 1, BASE + 10, 32'h0000_BEEF, SZ_H, LD_BU, 0);
    acc(1, 1, 0, BASE + 8,  32'h0, SZ_B, LD_W, 0);  @(negedge clk); chk("lit_lw8", rdata, 32'hBEEF_AA44);
    acc(1, 1, 0, BASE + 9,  32'h0, SZ_B, LD_BU, 0); @(negedge clk); chk("lit_lbu9", rdata, 32'h0000_00AA);
    acc(1, 1, 0, BASE + 10, 32'h0, SZ_B, LD_HU, 0); @(negedge clk); chk("lit_lhu10", rdata, 32'h0000_BEEF);
    acc(1, 1, 0, BASE + 11, 32'h0, SZ_B, LD_B, 0);  @(negedge clk); chk("lit_lb11", rdata, 32'h0000_00BE);
    acc(1, 1, 0, BASE + 8,  32'h0, SZ_B, LD_H, 0);  @(negedge clk); chk("lit_lh8", rdata, 32'h0000_AA44);
    acc(0, 1, 0, BASE + 8,  32'h0, SZ_B, LD_W, 0);  @(negedge clk); chk("lit_cs0", rdata, 32'h0);

    // Misaligned store: suppressed, first fault captured
    acc(1, 0, 1, BASE + 2, 32'hDEAD_BEEF, SZ_W, LD_BU, 0);
    acc(1, 1, 0, BASE + 0, 32'h0, SZ_B, LD_W, 0);
    @(negedge clk);
    chk("lit_mis_rd", rdata, 32'h0);
    chk("lit_mis_err", {31'b0, err}, 32'h1);
    chk("lit_mis_eaddr", err_addr, BASE + 2);
    acc(1, 1, 0, BASE + 5, 32'h0, SZ_B, LD_H, 0);
    idle();
    @(negedge clk); chk("lit_keep_eaddr", err_addr, BASE + 2);

    // Out of range with clr_err in the same cycle: fault wins
    acc(1, 1, 0, BASE + 32'h2000, 32'h0, SZ_B, LD_W, 1);
    @(negedge clk); chk("lit_oor_rd", rdata, 32'h0);
    idle();
    @(negedge clk);
    chk("lit_oor_err", {31'b0, err}, 32'h1);
    chk("lit_oor_eaddr", err_addr, BASE + 32'h2000);
    acc(0, 0, 0, BASE, 32'h0, SZ_B, LD_BU, 1);
    idle();
    @(negedge clk); chk("lit_clr", {31'b0, err}, 32'h0);

    // Same-cycle read and write of one word
    acc(1, 0, 1, BASE + 4, 32'h7, SZ_W, LD_BU, 0);
    acc(1, 1, 1, BASE + 4, 32'h5, SZ_W, LD_W, 0);
    @(negedge clk); chk("lit_raw_old", rdata, 32'h7);
    acc(1, 1, 0, BASE + 4, 32'h0, SZ_B, LD_W, 0);
    @(negedge clk); chk("lit_raw_new", rdata, 32'h5);

    // Illegal store size faults and leaves RAM untouched
    acc(1, 0, 1, BASE + 12, 32'h1, 2'd3, LD_BU, 0);
    acc(1, 1, 0, BASE + 12, 32'h0, SZ_B, LD_W, 0);
    @(negedge clk);
    chk("lit_ill_rd", rdata, 32'h0);
    chk("lit_ill_err", {31'b0, err}, 32'h1);
    acc(1, 1, 0, BASE + 12, 32'h0, SZ_B, 3'd6, 0);

    // Reset mid-fill restarts the sequence
    idle();
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    repeat (1000) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    wait_ready(n);
    chk("refill_cycles", n, 32'd2048);
    @(negedge clk);
    chk("lit_refill_err", {31'b0, err}, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory stage directly downstream of the single-cycle CPU core.
- Consumes the CPU's DM address, write data, chip-select, read/write strobes and store/load size codes; returns read data already lane-aligned to bit 0 for the core's load extension muxes.
- Owns the data RAM: byte-lane masked synchronous writes, combinational reads, a post-reset zero-fill sequencer, and sticky misalignment/range error capture.

Parameters:
- ADDR_W, 11, word-address width; DEPTH = 2**ADDR_W words.
- BASE, 32'h1001_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  access enable.
- r  in  1  read strobe.
- w  in  1  write strobe.
- addr  in  32  byte address.
- wdata  in  32  store data; byte/half data in low bits.
- ssize  in  2  store size: 0 word, 1 byte, 2 half, 3 illegal.
- lsize  in  3  load size: 0 lw, 1 lbu, 2 lhu, 3 lb, 4 lh, 5-7 illegal.
- clr_err  in  1  clears err on the next edge.
- rdata  out  32  aligned read data.
- ready  out  1  zero-fill complete.
- err  out  1  sticky access error.
- err_addr  out  32  address of the first faulting access.

Behaviour:
- Reset (rst=0, async): state INIT, fill counter 0, ready=0, err=0, err_addr=0. RAM contents are not cleared by reset itself.
- FSM INIT:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, go to RUN.
  - ready rises on the edge that enters RUN, so it is 1 exactly DEPTH cycles after reset release.
  - CPU accesses in INIT: writes are ignored, rdata=0, no error is flagged.
  - Reset asserted mid-INIT restarts the fill from 0.
- FSM RUN: remains in RUN until reset.
- Decode:
  - off = addr - BASE; idx = off[ADDR_W+1:2].
  - Out of range when off[31:ADDR_W+2] != 0.
- Misalignment:
  - word access with addr[1:0] != 0;
  - half access with addr[0] = 1;
  - any illegal ssize or lsize code.
- Write (RUN, cs&w, legal):
  - Lane mask: word = 1111; byte = 0001<<addr[1:0]; half = 0011<<(2*addr[1]).
  - Data is replicated into the lanes (byte to all 4, half to both halves).
  - Masked write to mem[idx] on the rising edge.
- Read (RUN, cs&r, legal): combinational.
  - word: mem[idx].
  - byte sizes: (mem[idx] >> 8*addr[1:0]) & 0xFF, zero-extended.
  - half sizes: (mem[idx] >> 16*addr[1]) & 0xFFFF.
  - Sign extension stays in the CPU core; lb/lh return zero-extended data here.
  - Otherwise rdata = 0.
- Same-cycle read and write to the same word: rdata shows pre-write contents; the new value is visible the next cycle.
- Faulting access (RUN, cs & (r|w), misaligned or out of range):
  - Write suppressed, rdata = 0.
  - err set on the edge.
  - err_addr loaded only if err was 0, so the first fault is kept.
- clr_err and a new fault in the same cycle: the fault wins (err stays 1, err_addr = new address).
- cs=0: no effect on RAM, error state or rdata (rdata = 0).

Decomposition:
- Package dmem_pkg holds:
  - ssize encodings: SZ_W, SZ_B, SZ_H;
  - lsize encodings: LD_W, LD_BU, LD_HU, LD_B, LD_H;
  - FSM state enum: ST_INIT, ST_RUN.
- Sub-module dmem_lane (combinational) takes ssize/lsize, addr[1:0] and wdata. It outputs the 4-bit lane mask, replicated write data, read shift amount, read width mask, and a misalign flag.
- RAM array and FSM live in dmem_ctrl.

Test Plan:
- Release reset, then hold cs=1, w=1, addr=BASE, wdata=32'hFFFF_FFFF during fill -> ready=0 for exactly 2048 cycles, then 1. Read of BASE returns 0; err=0.
- After ready:
  - sw 32'h1122_3344 @BASE+8;
  - sb wdata=32'hAA @BASE+9;
  - sh wdata=32'hBEEF @BASE+10;
  - lw @BASE+8 -> 32'hBEEF_AA44;
  - lbu @BASE+9 -> 32'h0000_00AA;
  - lhu @BASE+10 -> 32'h0000_BEEF.
- sw @BASE+2 -> no write; lw @BASE+0 unchanged; err=1, err_addr=BASE+2. A following lh @BASE+5 leaves err_addr=BASE+2.
- lw @BASE+32'h2000 (out of range) with clr_err=1 in the same cycle -> err=1, err_addr=BASE+32'h2000. clr_err alone next cycle -> err=0.
- cs=r=w=1, sw 32'h5 @BASE+4 where the word holds 32'h7 -> rdata=32'h7 that cycle, 32'h5 the next.
- Assert rst at fill count 1000, release -> ready returns after exactly 2048 further cycles.
